// File: rtl/evu_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : evu_counter_bank
// Purpose  : Bank of programmable hardware event counters. Each counter owns
//            a 4-bit event-select register that drives its event mux, samples
//            the single-bit event returned by that mux and accumulates it
//            into a CNT_WIDTH-bit counter. A shared status register holds
//            sticky overflow flags, per-counter inhibits and overflow
//            interrupt enables.
// Ports    : clk_i, rst_ni        - clock, asynchronous active-low reset
//            debug_mode_i        - freezes all counting while high
//            evu_event_i[k]      - event from the mux selected by counter k
//            sel_line_o[4k+3:4k] - event select for counter k
//            csr_we_i/csr_re_i   - register write/read strobes
//            csr_idx_i           - counter index
//            csr_reg_i           - kind: 0 select, 1 counter, 2 status, 3 rsvd
//            csr_wdata_i         - write data
//            csr_rdata_o         - registered read data (holds between reads)
//            csr_rvalid_o        - one-cycle read-valid pulse
//            ovf_irq_o           - level overflow interrupt
// Revision : 1.0 - initial release
// ============================================================================
module evu_counter_bank #(
   parameter int NUM_COUNTERS = 4,
   parameter int CNT_WIDTH    = 64,
   parameter int IDX_W        = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      debug_mode_i,
   input  logic [NUM_COUNTERS-1:0]   evu_event_i,
   output logic [4*NUM_COUNTERS-1:0] sel_line_o,
   input  logic                      csr_we_i,
   input  logic                      csr_re_i,
   input  logic [IDX_W-1:0]          csr_idx_i,
   input  logic [1:0]                csr_reg_i,
   input  logic [63:0]               csr_wdata_i,
   output logic [63:0]               csr_rdata_o,
   output logic                      csr_rvalid_o,
   output logic                      ovf_irq_o
);

   localparam int         N         = NUM_COUNTERS;
   localparam logic [1:0] KIND_SEL  = 2'd0;
   localparam logic [1:0] KIND_CNT  = 2'd1;
   localparam logic [1:0] KIND_STAT = 2'd2;

   logic [3:0]           sel [N];
   logic [CNT_WIDTH-1:0] cnt [N];
   logic [N-1:0]         ovf;
   logic [N-1:0]         inh;
   logic [N-1:0]         ovf_en;

   logic [N-1:0]         ovf_nxt;
   logic [N-1:0]         inh_nxt;
   logic [N-1:0]         ovf_en_nxt;
   logic [N-1:0]         inc;
   logic [N-1:0]         wrap;
   logic [N-1:0]         cnt_wr;
   logic [N-1:0]         sel_wr;
   logic                 stat_wr;
   logic                 idx_ok;
   logic [63:0]          rd_val;

   // Only the low bits of the write bus are architecturally meaningful.
   logic                 unused_wdata;
   assign unused_wdata = ^csr_wdata_i;

   assign idx_ok  = (32'(csr_idx_i) < 32'(N));
   assign stat_wr = csr_we_i && (csr_reg_i == KIND_STAT);

   for (genvar k = 0; k < N; k++) begin : g_ctl
      localparam logic [IDX_W-1:0] K_IDX = IDX_W'(k);

      assign sel_wr[k] = csr_we_i && (csr_reg_i == KIND_SEL) && (csr_idx_i == K_IDX);
      assign cnt_wr[k] = csr_we_i && (csr_reg_i == KIND_CNT) && (csr_idx_i == K_IDX);
      // Select codes 0 and 1 are unassigned, so bits [3:1] must be nonzero.
      assign inc[k]    = evu_event_i[k] && (sel[k][3:1] != 3'b000) && !inh[k] && !debug_mode_i;
      // A counter write drops the colliding event, so it cannot wrap either.
      assign wrap[k]   = inc[k] && !cnt_wr[k] && (&cnt[k]);
      assign sel_line_o[4*k +: 4] = sel[k];
   end

   // A wrap in the same cycle as a W1C of its flag keeps the flag set.
   assign ovf_nxt    = (stat_wr ? (ovf & ~csr_wdata_i[N-1:0]) : ovf) | wrap;
   assign inh_nxt    = stat_wr ? csr_wdata_i[2*N-1:N]   : inh;
   assign ovf_en_nxt = stat_wr ? csr_wdata_i[3*N-1:2*N] : ovf_en;

   // Read mux works on pre-edge state, so a same-cycle write or increment
   // is never visible to the read that coincides with it.
   always_comb begin
      rd_val = '0;
      case (csr_reg_i)
         KIND_SEL: begin
            for (int k = 0; k < N; k++) begin
               if (idx_ok && (csr_idx_i == IDX_W'(k))) rd_val = 64'(sel[k]);
            end
         end
         KIND_CNT: begin
            for (int k = 0; k < N; k++) begin
               if (idx_ok && (csr_idx_i == IDX_W'(k))) rd_val = 64'(cnt[k]);
            end
         end
         KIND_STAT: rd_val = 64'({ovf_en, inh, ovf});
         default:   rd_val = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < N; k++) begin
            sel[k] <= '0;
            cnt[k] <= '0;
         end
         ovf          <= '0;
         inh          <= '0;
         ovf_en       <= '0;
         csr_rdata_o  <= '0;
         csr_rvalid_o <= 1'b0;
         ovf_irq_o    <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (sel_wr[k]) sel[k] <= csr_wdata_i[3:0];
            if (cnt_wr[k])   cnt[k] <= csr_wdata_i[CNT_WIDTH-1:0];
            else if (inc[k]) cnt[k] <= cnt[k] + CNT_WIDTH'(1);
         end
         ovf          <= ovf_nxt;
         inh          <= inh_nxt;
         ovf_en       <= ovf_en_nxt;
         csr_rvalid_o <= csr_re_i;
         if (csr_re_i) csr_rdata_o <= rd_val;
         // Built from next-state so the interrupt follows the causing edge.
         ovf_irq_o    <= |(ovf_nxt & ovf_en_nxt);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_evu_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_evu_counter_bank
// Purpose  : Self-checking bench for evu_counter_bank (3 counters, 40-bit)
//            with directed scenarios and a randomized run against a
//            behavioural model of the counter bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_evu_counter_bank;

   localparam int N  = 3;
   localparam int CW = 40;
   localparam int IW = 2;
   localparam logic [CW-1:0] CMAX = '1;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b1;
   logic           dbg   = 1'b0;
   logic [N-1:0]   ev    = '0;
   logic           we    = 1'b0;
   logic           re    = 1'b0;
   logic [IW-1:0]  idx   = '0;
   logic [1:0]     kind  = '0;
   logic [63:0]    wdata = '0;
   logic [4*N-1:0] sel_line;
   logic [63:0]    rdata;
   logic           rvalid;
   logic           irq;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   evu_counter_bank #(.NUM_COUNTERS(N), .CNT_WIDTH(CW), .IDX_W(IW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .debug_mode_i (dbg),
      .evu_event_i  (ev),
      .sel_line_o   (sel_line),
      .csr_we_i     (we),
      .csr_re_i     (re),
      .csr_idx_i    (idx),
      .csr_reg_i    (kind),
      .csr_wdata_i  (wdata),
      .csr_rdata_o  (rdata),
      .csr_rvalid_o (rvalid),
      .ovf_irq_o    (irq)
   );

   // ---------------- behavioural reference model ----------------
   logic [3:0]    m_sel [N];
   logic [CW-1:0] m_cnt [N];
   logic [N-1:0]  m_ovf, m_inh, m_en;
   logic [63:0]   m_rdata;
   logic          m_rvalid, m_irq;

   task automatic m_clear();
      for (int c = 0; c < N; c++) begin
         m_sel[c] = '0;
         m_cnt[c] = '0;
      end
      m_ovf = '0; m_inh = '0; m_en = '0;
      m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
   endtask

   function automatic logic [63:0] m_read(input int i, input int k);
      if (k == 3) return 64'd0;
      if (k == 2) return 64'(m_ovf) | (64'(m_inh) << N) | (64'(m_en) << (2*N));
      if (i >= N) return 64'd0;
      if (k == 0) return 64'(m_sel[i]);
      return 64'(m_cnt[i]);
   endfunction

   task automatic m_edge();
      logic [N-1:0] wrapped;
      int i, k;
      wrapped = '0;
      i = int'(idx);
      k = int'(kind);
      if (re) m_rdata = m_read(i, k);
      m_rvalid = re;
      for (int c = 0; c < N; c++) begin
         if (we && k == 1 && i == c) begin
            m_cnt[c] = wdata[CW-1:0];
         end else if (ev[c] && m_sel[c] > 4'd1 && !m_inh[c] && !dbg) begin
            if (m_cnt[c] == CMAX) begin
               m_cnt[c] = '0;
               wrapped[c] = 1'b1;
            end else begin
               m_cnt[c] = m_cnt[c] + 1;
            end
         end
      end
      if (we && k == 2) begin
         m_ovf = m_ovf & ~wdata[N-1:0];
         m_inh = wdata[2*N-1:N];
         m_en  = wdata[3*N-1:2*N];
      end
      if (we && k == 0 && i < N) m_sel[i] = wdata[3:0];
      m_ovf = m_ovf | wrapped;
      m_irq = |(m_ovf & m_en);
   endtask

   // One clock cycle with the given inputs; returns #1 after the edge.
   task automatic cyc(input logic [N-1:0] e, input logic d, input logic w,
                      input logic r, input int i, input int k, input logic [63:0] wd);
      ev = e; dbg = d; we = w; re = r; idx = IW'(i); kind = 2'(k); wdata = wd;
      @(posedge clk);
      m_edge();
      #1;
      ev = '0; dbg = 1'b0; we = 1'b0; re = 1'b0; idx = '0; kind = '0; wdata = '0;
   endtask

   task automatic wr(input int k, input int i, input logic [63:0] wd);
      cyc('0, 1'b0, 1'b1, 1'b0, i, k, wd);
   endtask

   task automatic rd(input int k, input int i);
      cyc('0, 1'b0, 1'b0, 1'b1, i, k, 64'd0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      m_clear();
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (sel_line !== '0) begin fails++; $display("FAIL rst_sel_line: got %h want 0", sel_line); end
      tests++; if (rdata !== 64'd0) begin fails++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      tests++; if (rvalid !== 1'b0 || irq !== 1'b0) begin fails++; $display("FAIL rst_flags: got rvalid=%b irq=%b want 0 0", rvalid, irq); end
      rst_n = 1'b1;
      // count a little, leave a read pending, then reset mid-operation
      wr(0, 0, 64'd2);
      repeat (3) cyc(3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
      rd(1, 0);
      tests++; if (rdata !== 64'd3 || rvalid !== 1'b1) begin fails++; $display("FAIL pre_rst_read: got %0d/%b want 3/1", rdata, rvalid); end
      rst_n = 1'b0;
      m_clear();
      #2;
      tests++; if (rvalid !== 1'b0 || rdata !== 64'd0 || sel_line !== '0 || irq !== 1'b0)
         begin fails++; $display("FAIL midrst_outputs: got rvalid=%b rdata=%h sel=%h irq=%b want all 0", rvalid, rdata, sel_line, irq); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      // select write on counter 1 with a coincident event under the old (0) select
      cyc(3'b010, 1'b0, 1'b1, 1'b0, 1, 0, 64'd3);
      tests++; if (sel_line[7:4] !== 4'h3 || sel_line[3:0] !== 4'h0)
         begin fails++; $display("FAIL sel_write: got %h want 030", sel_line); end
      rd(1, 1);
      tests++; if (rdata !== 64'd0 || rvalid !== 1'b1) begin fails++; $display("FAIL cnt1_old_sel: got %0d/%b want 0/1", rdata, rvalid); end
   endtask

   task automatic test_counting();
      wr(0, 0, 64'd2);
      repeat (5) cyc(3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
      rd(1, 0);
      tests++; if (rdata !== 64'd5 || rvalid !== 1'b1) begin fails++; $display("FAIL count5: got %0d/%b want 5/1", rdata, rvalid); end
      cyc('0, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
      tests++; if (rvalid !== 1'b0 || rdata !== 64'd5) begin fails++; $display("FAIL rdata_hold: got %0d/%b want 5/0", rdata, rvalid); end
      wr(2, 0, 64'h8);  // inh[0]
      repeat (5) cyc(3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
      rd(1, 0);
      tests++; if (rdata !== 64'd5) begin fails++; $display("FAIL inhibit: got %0d want 5", rdata); end
      wr(2, 0, 64'h0);
      repeat (5) cyc(3'b001, 1'b1, 1'b0, 1'b0, 0, 0, 64'd0);
      rd(1, 0);
      tests++; if (rdata !== 64'd5) begin fails++; $display("FAIL debug_freeze: got %0d want 5", rdata); end
      cyc(3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
      rd(1, 0);
      tests++; if (rdata !== 64'd6) begin fails++; $display("FAIL resume: got %0d want 6", rdata); end
   endtask

   task automatic test_wrap();
      wr(1, 2, 64'hFFFF_FFFF_FFFF_FFFF);
      rd(1, 2);
      tests++; if (rdata !== 64'h0000_00FF_FFFF_FFFF) begin fails++; $display("FAIL width_trunc: got %h want 000000ffffffffff", rdata); end
      wr(0, 2, 64'd2);
      wr(2, 0, 64'h100);  // ovf_en[2]
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b want 0", irq); end
      cyc(3'b100, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_rise: got %b want 1", irq); end
      rd(1, 2);
      tests++; if (rdata !== 64'd0) begin fails++; $display("FAIL wrap_zero: got %h want 0", rdata); end
      rd(2, 0);
      tests++; if (rdata !== 64'h104) begin fails++; $display("FAIL ovf_status: got %h want 104", rdata); end
      wr(2, 0, 64'h104);  // W1C ovf[2], keep ovf_en[2]
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_fall: got %b want 0", irq); end
      rd(2, 0);
      tests++; if (rdata !== 64'h100) begin fails++; $display("FAIL ovf_cleared: got %h want 100", rdata); end
   endtask

   task automatic test_collision();
      cyc(3'b001, 1'b0, 1'b1, 1'b0, 0, 1, 64'd100);
      rd(1, 0);
      tests++; if (rdata !== 64'd100) begin fails++; $display("FAIL wr_vs_inc: got %0d want 100", rdata); end
      wr(1, 2, 64'h0000_00FF_FFFF_FFFF);
      cyc(3'b100, 1'b0, 1'b1, 1'b0, 0, 2, 64'h104);  // W1C coincident with wrap
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL set_wins_irq: got %b want 1", irq); end
      rd(2, 0);
      tests++; if (rdata !== 64'h104) begin fails++; $display("FAIL set_wins_ovf: got %h want 104", rdata); end
      cyc('0, 1'b0, 1'b1, 1'b1, 0, 1, 64'd777);
      tests++; if (rdata !== 64'd100 || rvalid !== 1'b1) begin fails++; $display("FAIL rw_old: got %0d/%b want 100/1", rdata, rvalid); end
      rd(1, 0);
      tests++; if (rdata !== 64'd777) begin fails++; $display("FAIL rw_new: got %0d want 777", rdata); end
   endtask

   task automatic test_illegal();
      cyc('0, 1'b0, 1'b1, 1'b1, N, 1, 64'd55);
      tests++; if (rdata !== 64'd0 || rvalid !== 1'b1) begin fails++; $display("FAIL idx_oor: got %h/%b want 0/1", rdata, rvalid); end
      cyc('0, 1'b0, 1'b1, 1'b1, 0, 3, 64'd55);
      tests++; if (rdata !== 64'd0 || rvalid !== 1'b1) begin fails++; $display("FAIL kind3: got %h/%b want 0/1", rdata, rvalid); end
      rd(1, 0);
      tests++; if (rdata !== 64'd777) begin fails++; $display("FAIL illegal_no_effect: got %0d want 777", rdata); end
      rd(2, 0);
      tests++; if (rdata !== 64'h104) begin fails++; $display("FAIL illegal_status: got %h want 104", rdata); end
      wr(0, 1, 64'hFF);
      tests++; if (sel_line[7:4] !== 4'hF) begin fails++; $display("FAIL sel_ff_line: got %h want f", sel_line[7:4]); end
      rd(0, 1);
      tests++; if (rdata !== 64'hF) begin fails++; $display("FAIL sel_ff_read: got %h want f", rdata); end
   endtask

   task automatic test_random();
      logic [N-1:0] e;
      logic         d, w, r;
      int           i, k;
      logic [63:0]  wd;
      for (int n = 0; n < 400; n++) begin
         e  = N'($urandom);
         d  = ($urandom_range(0, 7) == 0);
         w  = ($urandom_range(0, 3) == 0);
         r  = 1'($urandom_range(0, 1));
         k  = $urandom_range(0, 3);
         i  = $urandom_range(0, 3);
         if (k == 2 && i >= N) i = $urandom_range(0, N-1);
         wd = {$urandom, $urandom};
         if (k == 1 && $urandom_range(0, 1) == 1) wd = 64'(CMAX) - 64'($urandom_range(0, 3));
         cyc(e, d, w, r, i, k, wd);
         tests++; if (rvalid !== m_rvalid || rdata !== m_rdata)
            begin fails++; $display("FAIL rnd_read[%0d]: got %h/%b want %h/%b", n, rdata, rvalid, m_rdata, m_rvalid); end
         tests++; if (irq !== m_irq) begin fails++; $display("FAIL rnd_irq[%0d]: got %b want %b", n, irq, m_irq); end
         tests++; if (sel_line !== {m_sel[2], m_sel[1], m_sel[0]})
            begin fails++; $display("FAIL rnd_sel[%0d]: got %h want %h", n, sel_line, {m_sel[2], m_sel[1], m_sel[0]}); end
      end
      for (int c = 0; c < N; c++) begin
         rd(1, c);
         tests++; if (rdata !== 64'(m_cnt[c])) begin fails++; $display("FAIL rnd_final_cnt%0d: got %h want %h", c, rdata, 64'(m_cnt[c])); end
      end
   endtask

   initial begin
      test_reset();
      test_counting();
      test_wrap();
      test_collision();
      test_illegal();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/evu_counter_bank.md
# evu_counter_bank

Programmable hardware event counter bank for the core's event unit. Holds NUM_COUNTERS event-select registers that drive the per-counter event-mux select lines, samples the single-bit event returned by each mux, and accumulates events into wide counters. Sits between the CSR file, which reads and writes it through a simple register port, and the event muxes; it also raises an overflow interrupt toward the CSR/interrupt logic.

## Interface
- NUM_COUNTERS, 4, number of counter/selector pairs (1..16)
- CNT_WIDTH, 64, counter width in bits (33..64)
- IDX_W, $clog2(NUM_COUNTERS) (min 1), counter index width
- clk_i  in  1  core clock; all state updates on the rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- debug_mode_i  in  1  high freezes all counting
- evu_event_i  in  NUM_COUNTERS  bit k: event from the mux driven by sel_line_o[k]
- sel_line_o  out  4*NUM_COUNTERS  bits [4k+3:4k]: event select for counter k
- csr_we_i  in  1  write strobe
- csr_re_i  in  1  read strobe
- csr_idx_i  in  IDX_W  counter index
- csr_reg_i  in  2  register kind: 0 select, 1 counter, 2 status, 3 reserved
- csr_wdata_i  in  64  write data
- csr_rdata_o  out  64  read data, registered
- csr_rvalid_o  out  1  read data valid pulse
- ovf_irq_o  out  1  overflow interrupt, level

## Operation
- Reset values: all select registers 0, counters 0, ovf/inh/ovf_en 0, sel_line_o 0, csr_rdata_o 0, csr_rvalid_o 0, ovf_irq_o 0.
- Select register k: 4 bits, written from csr_wdata_i[3:0]; upper bits ignored, read back as zero. Driven directly onto sel_line_o[k].
- Select codes 0000 and 0001 are unassigned; counter k does not count while its select is either code.
- Counter k increments by 1 when all hold: evu_event_i[k]=1, sel_k not 0/1, inh[k]=0, debug_mode_i=0.
- Counter width rule: writes take csr_wdata_i[CNT_WIDTH-1:0]; reads zero-extend to 64.
- Wrap: increment at all-ones yields 0 and sets ovf[k] (sticky).
- Status register (kind 2, index ignored): bits [N-1:0] ovf (write-1-to-clear), [2N-1:N] inh (read/write), [3N-1:2N] ovf_en (read/write); remaining bits read 0.
- ovf_irq_o = OR over k of (ovf[k] AND ovf_en[k]), registered from state.
- Collisions:
  - Counter write and increment in the same cycle: the write value is stored and the event is dropped.
  - ovf W1C and a new wrap in the same cycle: the set wins.
  - Select write: the new code takes effect on the following cycle. An event sampled during the write cycle counts under the old select.
- Out-of-range index (idx >= NUM_COUNTERS) or kind 3: write ignored; read returns 0 with rvalid.
- csr_we_i and csr_re_i together: the read returns pre-write contents.

## Timing
- Event to count: event sampled at edge t; counter value updated after edge t; readable by re at t+1.
- Read latency 1: re sampled at edge t; csr_rdata_o/csr_rvalid_o valid after edge t for exactly one cycle. rdata holds its last value otherwise.
- Reads return the counter value before any same-cycle increment.
- Back-to-back reads every cycle are supported; no stall.
- ovf_irq_o rises the cycle after the wrap edge, or after the edge that sets ovf_en with ovf already set. It falls the cycle after the clearing write.
- sel_line_o changes the cycle after the select write.
- Asynchronous reset mid-operation clears all state and outputs immediately, including a pending rvalid. Counting resumes on the first edge after deassertion.
- Events while debug_mode_i=1 or inhibited are lost, not deferred.

## Test plan
- Reset/select path:
  - Stimulus: assert rst_ni=0 mid-count, release, then write select k=1 with 0x3 (kind 0).
  - Required: every output is 0 during reset. sel_line_o[7:4]=0011 one cycle after the write. Counter 1 stays 0 while select is still 0.
- Counting and hold-off:
  - Stimulus: select 0x2 on counter 0; pulse evu_event_i[0] for 5 cycles; read counter 0.
  - Required: rdata=5 with rvalid one cycle after re.
  - Stimulus: repeat with inh[0]=1, then with debug_mode_i=1.
  - Required: count stays 5 in both cases.
- Wrap and interrupt:
  - Stimulus: write counter 2 with all-ones; set ovf_en[2]; pulse one event.
  - Required: counter reads 0; ovf[2]=1; ovf_irq_o=1 the next cycle.
  - Stimulus: W1C ovf[2].
  - Required: irq drops the cycle after the write.
- Collisions:
  - Stimulus: counter write of 100 with a simultaneous event.
  - Required: counter reads 100.
  - Stimulus: W1C on ovf with a simultaneous wrap.
  - Required: ovf stays 1.
  - Stimulus: read and write the same counter in one cycle.
  - Required: the read returns the old value.
- Illegal accesses:
  - Stimulus: idx=NUM_COUNTERS, or kind 3, read and write.
  - Required: state unchanged; rdata=0 with rvalid=1.
  - Stimulus: select write of 0xFF.
  - Required: stores and reads back 0xF.
